uart_rx_word: RTL and testbench
===============================

Name: uart_rx_word

Overview:
- UART 8N1 receiver that assembles four consecutive bytes into one 32-bit word.
- Counterpart of the existing 32-bit UART transmit path. Used on the host-link/loopback side to reconstruct the FFA result words sent out on uart_tx_pin, and to accept 32-bit configuration words into the design.
- Reports framing errors and inter-byte timeouts so that a partial word is never delivered.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434 at defaults): clocks per bit. Derived; must be ≥ 4.
- TIMEOUT_BITS, 20: maximum idle gap between bytes of one word, in bit periods.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- rx_in, input, 1: serial line, asynchronous to clk. Idles high.
- data_out, output, 32: last complete word. Held stable until the next word completes.
- data_valid, output, 1: one-cycle strobe marking a new data_out.
- frame_err, output, 1: one-cycle strobe on a bad stop bit.
- timeout_err, output, 1: one-cycle strobe when a partial word is abandoned.
- rx_busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, data_valid=0, frame_err=0, timeout_err=0, rx_busy=0.
  - FSM enters IDLE; byte count=0; bit count=0; baud counter=0; timeout counter=0.
  - Synchronizer flops reset to 1.
  - Assertion mid-frame discards all partial data. Release resumes in IDLE.
- Input synchronization:
  - rx_in passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
  - This adds 2 cycles of latency to every edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On rx_s=0, load the baud counter and go to START.
  - Otherwise, if byte count is nonzero, increment the timeout counter.
  - When the timeout counter reaches TIMEOUT_BITS*CLKS_PER_BIT: pulse timeout_err, clear byte count and timeout counter.
- START:
  - After CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
  - If rx_s=0: go to DATA with the baud counter reloaded to CLKS_PER_BIT.
  - If rx_s=1: false start. Return to IDLE with no strobe and byte count unchanged.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles, i.e. at the bit centres.
  - Shift bits in LSB-first. After the 8th sample, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If 1: byte accepted.
    - Byte k (k=0..3) is written to word bits [31-8k:24-8k], so the first byte received is the MSB.
    - Byte count increments; timeout counter clears.
    - If byte count was 3: on the next clock, data_out is updated with the full word, data_valid pulses for one cycle, and byte count wraps to 0.
  - If 0: pulse frame_err, clear byte count, and keep data_out unchanged.
  - Either way, return to IDLE immediately at the mid-stop sample. This gives half a bit of margin for back-to-back frames.
- Latency:
  - data_valid rises 1 cycle after the 4th stop-bit sample.
  - The 4th stop-bit sample is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after that frame's start edge reaches rx_in.
- Simultaneous events:
  - A start edge on the same cycle the timeout expires: the timeout wins. The byte count is cleared and the new frame becomes byte 0.
  - frame_err and data_valid are never asserted together.
  - At most one of data_valid, frame_err, timeout_err is high in any cycle.
- Other boundary conditions:
  - There is no backpressure. A consumer that ignores data_valid loses the word, because data_out is simply overwritten by the next word.
  - A break condition (line held low) produces frame_err once. The FSM then sits in START/IDLE until the line returns high, re-arming on each low sample.

Test Plan:
- Reset then idle high for 1000 cycles -> all outputs 0, rx_busy=0.
- Bytes 0xDE,0xAD,0xBE,0xEF sent back-to-back at 115200 baud -> exactly one data_valid. data_out=0xDEADBEEF. Strobe 1 cycle after the 4th stop-bit sample; rx_busy falls with it.
- Two words 0x12345678 then 0xCAFEF00D sent back-to-back -> two data_valid strobes with the matching values. data_out holds 0x12345678 in between.
- Second byte sent with stop bit=0 -> frame_err pulses once. The following 4 good bytes 0x01,0x02,0x03,0x04 yield data_out=0x01020304.
- Two bytes sent, then idle for 21 bit periods -> timeout_err pulses once at 20 bit periods. The next 4 bytes form one word; no stale bytes appear in it.
- Low glitch of 100 cycles on an idle line -> no strobes, FSM back in IDLE. rst pulsed low mid-byte -> outputs reset immediately and the next full word is received correctly.

Source files
------------

// File: rtl/uart_rx_word_if.sv
// Receive-side bundle of uart_rx_word: serial line in, assembled word and status strobes out.
// master = the receiver, slave = the word consumer that also owns the serial line.
interface uart_rx_word_if;
  logic        rx_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        timeout_err;
  logic        rx_busy;

  modport master (
    input  rx_in,
    output data_out,
    output data_valid,
    output frame_err,
    output timeout_err,
    output rx_busy
  );

  modport slave (
    output rx_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  timeout_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_word.sv
// UART 8N1 receiver packing four bytes (first byte = MSB) into one word; data_valid lands one cycle after the 4th mid-stop sample.
// No backpressure: a word not taken on its data_valid strobe is overwritten by the next one; partial words are dropped on error.
module uart_rx_word #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_word_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BW-1:0] HALF_BIT     = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] FULL_BIT     = BW'(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_ONE     = BW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [23:0]   word_q, word_d;
  logic          brk_q, brk_d;
  logic [31:0]   data_q, data_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          te_q, te_d;
  logic          baud_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= bus.rx_in;
      rx_s    <= sync1_q;
    end
  end

  assign baud_tick = (baud_q == BAUD_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tmo_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tmo_q   <= tmo_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      te_q    <= te_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    brk_d   = brk_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    te_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s) brk_d = 1'b0;
        // Expiry is checked before the start test so a coincident start edge becomes byte 0.
        if (byte_q != 2'd0) begin
          if (tmo_q == TIMEOUT_LAST) begin
            te_d   = 1'b1;
            byte_d = 2'd0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        if (!rx_s) begin
          state_d = START;
          baud_d  = HALF_BIT;
        end
      end
      START: begin
        if (baud_tick) begin
          // A low sample while a break is still latched only re-arms, it never opens a frame.
          if (rx_s || brk_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            baud_d  = FULL_BIT;
            bit_d   = 3'd0;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          baud_d  = FULL_BIT;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          if (rx_s) begin
            tmo_d  = '0;
            byte_d = byte_q + 1'b1;
            word_d = {word_q[15:0], shreg_q};
            if (byte_q == 2'd3) begin
              data_d = {word_q, shreg_q};
              dv_d   = 1'b1;
            end
          end else begin
            fe_d   = 1'b1;
            byte_d = 2'd0;
            brk_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = fe_q;
  assign bus.timeout_err = te_q;
  assign bus.rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed and random serial traffic; expected strobes (kind, word, cycle) come from a byte-level model
// and are checked by an independent monitor as the DUT raises them.
module tb_uart_rx_word;
  localparam int CLK_FREQ     = 2419200;
  localparam int BAUD_RATE    = 115200;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = CPB / 2;
  localparam int TCLK         = TIMEOUT_BITS * CPB;
  // Cycles from driving a start bit to the cycle its stop-bit strobe is visible.
  localparam int LAT          = 3 + HALF + 9 * CPB;

  typedef enum int {EV_WORD, EV_FERR, EV_TMO} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] word;
    int          at;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ev_t         exp_q[$];
  logic [7:0]  part[$];
  int          last_stop = 0;
  logic [31:0] mon_word = '0;
  logic        prev_busy = 1'b0;
  int          hold_err = 0;
  logic [7:0]  rb;
  int          rsel;

  uart_rx_word_if bus ();

  uart_rx_word #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    int c;
    c = cyc;
    if (stop_ok) begin
      part.push_back(b);
      last_stop = c + LAT;
      if (part.size() == 4) begin
        exp_q.push_back('{EV_WORD, {part[0], part[1], part[2], part[3]}, c + LAT});
        part.delete();
      end
    end else begin
      exp_q.push_back('{EV_FERR, 32'h0, c + LAT});
      part.delete();
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  // Line high for g cycles; a pending partial word is abandoned once the silence since its last stop reaches TCLK.
  task automatic idle(input int g);
    if (part.size() != 0 && (cyc + g + 3 - last_stop) >= TCLK) begin
      exp_q.push_back('{EV_TMO, 32'h0, last_stop + TCLK});
      part.delete();
    end
    bus.rx_in = 1'b1;
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic line_low(input int n);
    bus.rx_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
  endtask

  always @(negedge clk) begin
    ev_t        e;
    logic [2:0] want;
    if (rst === 1'b0) begin
      mon_word = '0;
    end else if (bus.data_valid || bus.frame_err || bus.timeout_err) begin
      check("one_strobe", $countones({bus.data_valid, bus.frame_err, bus.timeout_err}), 1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got dv=%b fe=%b te=%b, required none (cycle %0d)",
                 bus.data_valid, bus.frame_err, bus.timeout_err, cyc);
      end else begin
        e = exp_q.pop_front();
        want = (e.kind == EV_WORD) ? 3'b100 : (e.kind == EV_FERR) ? 3'b010 : 3'b001;
        check("strobe_kind", {29'h0, bus.data_valid, bus.frame_err, bus.timeout_err}, {29'h0, want});
        check("strobe_cycle", cyc, e.at);
        if (e.kind == EV_WORD) begin
          check("data_out", bus.data_out, e.word);
          check("busy_before_dv", prev_busy, 1);
          check("busy_at_dv", bus.rx_busy, 0);
          mon_word = e.word;
        end else begin
          check("data_hold_on_err", bus.data_out, mon_word);
        end
      end
    end else if (bus.data_out !== mon_word) begin
      hold_err++;
    end
    prev_busy = bus.rx_busy;
  end

  initial begin
    bus.rx_in = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (1000) @(posedge clk);
    #1;
    check("reset_data_out", bus.data_out, 0);
    check("reset_dv", bus.data_valid, 0);
    check("reset_fe", bus.frame_err, 0);
    check("reset_te", bus.timeout_err, 0);
    check("reset_busy", bus.rx_busy, 0);

    send(8'hDE, 1); send(8'hAD, 1); send(8'hBE, 1); send(8'hEF, 1);
    idle(2 * CPB);

    send(8'h12, 1); send(8'h34, 1); send(8'h56, 1); send(8'h78, 1);
    send(8'hCA, 1); send(8'hFE, 1); send(8'hF0, 1); send(8'h0D, 1);
    idle(2 * CPB);

    send(8'hAA, 1); send(8'h55, 0);
    idle(3 * CPB);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    idle(2 * CPB);

    send(8'h11, 1); send(8'h22, 1);
    idle(21 * CPB);
    send(8'h33, 1); send(8'h44, 1); send(8'h55, 1); send(8'h66, 1);
    idle(2 * CPB);

    // Gap one cycle short of the timeout, then exactly on it (start edge and expiry coincide).
    send(8'h10, 1); send(8'h20, 1);
    idle(TCLK - CPB + HALF - 1);
    send(8'h30, 1); send(8'h40, 1);
    idle(2 * CPB);
    send(8'h50, 1); send(8'h60, 1);
    idle(TCLK - CPB + HALF);
    send(8'h70, 1); send(8'h80, 1); send(8'h90, 1); send(8'hA0, 1);
    idle(2 * CPB);

    exp_q.push_back('{EV_FERR, 32'h0, cyc + LAT});
    line_low(30 * CPB);
    idle(3 * CPB);

    line_low(HALF / 2);
    idle(3 * CPB);
    check("glitch_busy", bus.rx_busy, 0);

    bus.rx_in = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("busy_mid_byte", bus.rx_busy, 1);
    rst = 1'b0;
    bus.rx_in = 1'b1;
    part.delete();
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy", bus.rx_busy, 0);
    check("rst_dv", bus.data_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * CPB);
    send(8'hA5, 1); send(8'h5A, 1); send(8'h0F, 1); send(8'hF0, 1);
    idle(2 * CPB);

    for (int n = 0; n < 100; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        send(rb, 0);
        idle(2 * CPB + $urandom_range(0, 40));
      end else begin
        send(rb, 1);
        rsel = $urandom_range(0, 19);
        if (rsel == 0) idle($urandom_range(TCLK - CPB + HALF, TCLK + 200));
        else if (rsel < 8) idle($urandom_range(0, 60));
      end
    end

    idle(30 * CPB);
    check("all_expected_seen", exp_q.size(), 0);
    check("data_out_hold", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
